// File: rtl/icache_pkg.sv
// Shared types, field widths and address-slicing helpers for the instruction cache.
package icache_pkg;

    localparam int OFFSET_W   = 2;
    localparam int INDEX_W    = 3;
    localparam int TAG_W      = 3;
    localparam int BLOCK_W    = 128;
    localparam int WORD_W     = 32;
    localparam int MEM_ADDR_W = TAG_W + INDEX_W;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_READ = 2'd1,
        UPDATE   = 2'd2
    } icache_state_e;

    // Helpers take the word address (PC[9:2]) with the original bit numbering,
    // so the byte-offset bits never enter the cache logic.
    function automatic logic [OFFSET_W-1:0] get_offset(input logic [9:2] pc_word);
        return pc_word[3:2];
    endfunction

    function automatic logic [INDEX_W-1:0] get_index(input logic [9:2] pc_word);
        return pc_word[6:4];
    endfunction

    function automatic logic [TAG_W-1:0] get_tag(input logic [9:2] pc_word);
        return pc_word[9:7];
    endfunction

    // Word 0 lives in the least significant 32 bits of a block.
    function automatic logic [WORD_W-1:0] get_word(input logic [BLOCK_W-1:0] block,
                                                   input logic [OFFSET_W-1:0] offset);
        return block[{offset, 5'd0} +: WORD_W];
    endfunction

endpackage

// File: rtl/icache_ctrl.sv
// Miss-handling controller: sequences a block fetch from instruction memory
// and hands the captured block to the arrays for installation.
module icache_ctrl
    import icache_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  miss,
    input  logic [TAG_W-1:0]      req_tag,
    input  logic [INDEX_W-1:0]    req_index,
    input  logic                  mem_busywait,
    input  logic [BLOCK_W-1:0]    mem_readdata,
    output logic                  state_idle,
    output logic                  fill_we,
    output logic [TAG_W-1:0]      fill_tag,
    output logic [INDEX_W-1:0]    fill_index,
    output logic [BLOCK_W-1:0]    fill_data,
    output logic                  mem_read,
    output logic [MEM_ADDR_W-1:0] mem_address
);

    icache_state_e         state_r;
    logic [TAG_W-1:0]      miss_tag_r;
    logic [INDEX_W-1:0]    miss_index_r;
    logic [BLOCK_W-1:0]    fill_r;
    logic                  mem_read_r;
    logic [MEM_ADDR_W-1:0] mem_address_r;

    // FSM with registered memory request; the miss address is latched on entry so
    // a PC that moves during the stall cannot corrupt the fill.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            miss_tag_r    <= {TAG_W{1'b0}};
            miss_index_r  <= {INDEX_W{1'b0}};
            fill_r        <= {BLOCK_W{1'b0}};
            mem_read_r    <= 1'b0;
            mem_address_r <= {MEM_ADDR_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (miss) begin
                        state_r       <= MEM_READ;
                        miss_tag_r    <= req_tag;
                        miss_index_r  <= req_index;
                        mem_read_r    <= 1'b1;
                        mem_address_r <= {req_tag, req_index};
                    end else begin
                        state_r       <= IDLE;
                    end
                end
                MEM_READ: begin
                    if (!mem_busywait) begin
                        state_r    <= UPDATE;
                        fill_r     <= mem_readdata;
                        mem_read_r <= 1'b0;
                    end else begin
                        state_r    <= MEM_READ;
                    end
                end
                UPDATE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r    <= IDLE;
                    mem_read_r <= 1'b0;
                end
            endcase
        end
    end

    assign state_idle  = (state_r == IDLE);
    assign fill_we     = (state_r == UPDATE);
    assign fill_tag    = miss_tag_r;
    assign fill_index  = miss_index_r;
    assign fill_data   = fill_r;
    assign mem_read    = mem_read_r;
    assign mem_address = mem_address_r;

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: same-cycle hits, block refill on miss
// while the CPU is stalled through BUSYWAIT.
module instruction_cache
    import icache_pkg::*;
#(
    parameter int ADDR_W          = 10,
    parameter int NUM_BLOCKS      = 8,
    parameter int WORDS_PER_BLOCK = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [31:0]           PC,
    output logic [31:0]           INSTRUCTION,
    output logic                  BUSYWAIT,
    output logic                  mem_read,
    output logic [MEM_ADDR_W-1:0] mem_address,
    input  logic [BLOCK_W-1:0]    mem_readdata,
    input  logic                  mem_busywait
);

    localparam int LINE_W = WORDS_PER_BLOCK * WORD_W;

    logic [ADDR_W-1:2]     pc_word_s;
    logic [OFFSET_W-1:0]   offset_s;
    logic [INDEX_W-1:0]    index_s;
    logic [TAG_W-1:0]      tag_s;
    logic                  hit_s;
    logic                  unused_pc_bits_s;

    logic [NUM_BLOCKS-1:0] valid_r;
    logic [TAG_W-1:0]      tag_r  [NUM_BLOCKS];
    logic [LINE_W-1:0]     data_r [NUM_BLOCKS];

    logic                  state_idle_s;
    logic                  fill_we_s;
    logic [TAG_W-1:0]      fill_tag_s;
    logic [INDEX_W-1:0]    fill_index_s;
    logic [BLOCK_W-1:0]    fill_data_s;

    assign pc_word_s        = PC[ADDR_W-1:2];
    assign unused_pc_bits_s = ^{PC[31:ADDR_W], PC[1:0]};
    assign offset_s         = get_offset(pc_word_s);
    assign index_s          = get_index(pc_word_s);
    assign tag_s            = get_tag(pc_word_s);

    // Lookup against the indexed line; tags are never reset, valid gates them.
    always_comb begin
        hit_s = 1'b0;
        if (valid_r[index_s] && (tag_r[index_s] == tag_s)) begin
            hit_s = 1'b1;
        end else begin
            hit_s = 1'b0;
        end
    end

    // Word mux; data is uninitialised after reset, so a miss returns zero instead.
    always_comb begin
        INSTRUCTION = 32'd0;
        if (hit_s) begin
            INSTRUCTION = get_word(data_r[index_s], offset_s);
        end else begin
            INSTRUCTION = 32'd0;
        end
    end

    // Stall whenever the word is not present or a refill is still in flight.
    always_comb begin
        BUSYWAIT = 1'b0;
        if (!RESET) begin
            BUSYWAIT = 1'b0;
        end else if (!hit_s || !state_idle_s) begin
            BUSYWAIT = 1'b1;
        end else begin
            BUSYWAIT = 1'b0;
        end
    end

    // Valid bits: cleared by reset, set when a refill is installed.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            valid_r <= {NUM_BLOCKS{1'b0}};
        end else if (fill_we_s) begin
            valid_r[fill_index_s] <= 1'b1;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Tag and data arrays: written only on refill, never while reset is held.
    always_ff @(posedge CLK) begin
        if (RESET && fill_we_s) begin
            tag_r[fill_index_s]  <= fill_tag_s;
            data_r[fill_index_s] <= fill_data_s;
        end
    end

    icache_ctrl u_ctrl (
        .clk          (CLK),
        .rst_n        (RESET),
        .miss         (!hit_s),
        .req_tag      (tag_s),
        .req_index    (index_s),
        .mem_busywait (mem_busywait),
        .mem_readdata (mem_readdata),
        .state_idle   (state_idle_s),
        .fill_we      (fill_we_s),
        .fill_tag     (fill_tag_s),
        .fill_index   (fill_index_s),
        .fill_data    (fill_data_s),
        .mem_read     (mem_read),
        .mem_address  (mem_address)
    );

endmodule

// File: tb/tb_instruction_cache.sv
// Self-checking bench for instruction_cache with a behavioural block memory
// and a queue of expected fetch results.
module tb_instruction_cache;

    logic         CLK;
    logic         RESET;
    logic [31:0]  PC;
    logic [31:0]  INSTRUCTION;
    logic         BUSYWAIT;
    logic         mem_read;
    logic [5:0]   mem_address;
    logic [127:0] mem_readdata;
    logic         mem_busywait;

    logic [127:0] blocks [0:63];
    logic [31:0]  exp_q [$];
    int           mem_lat;
    int           checks;
    int           failures;

    instruction_cache dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .PC           (PC),
        .INSTRUCTION  (INSTRUCTION),
        .BUSYWAIT     (BUSYWAIT),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_readdata (mem_readdata),
        .mem_busywait (mem_busywait)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] word_at(input logic [9:0] a);
        logic [127:0] b;
        b = blocks[a[9:4]];
        return b[a[3:2]*32 +: 32];
    endfunction

    // Block memory: busy for mem_lat-1 cycles of a read request, data on the last.
    initial begin
        int cnt;
        cnt          = 0;
        mem_busywait = 1'b0;
        mem_readdata = 128'd0;
        forever begin
            @(posedge CLK);
            #1;
            if (mem_read === 1'b1) begin
                cnt++;
                mem_busywait = (cnt < mem_lat);
                mem_readdata = (cnt >= mem_lat) ? blocks[mem_address] : 128'd0;
            end else begin
                cnt          = 0;
                mem_busywait = 1'b0;
            end
        end
    end

    // Present addr, wait for BUSYWAIT to fall, then check word, stall length and refill address.
    task automatic fetch(input logic [9:0] addr, input bit align, input int exp_stall,
                         input bit exp_miss, input logic [5:0] exp_maddr, input string name);
        int          stall;
        bit          saw;
        bit          done;
        logic [5:0]  seen;
        logic [31:0] exp;
        if (align) begin
            @(posedge CLK);
            #1;
        end
        PC = {22'd0, addr};
        exp_q.push_back(word_at(addr));
        stall = 0;
        saw   = 1'b0;
        done  = 1'b0;
        seen  = 6'd0;
        while (!done) begin
            @(negedge CLK);
            if (mem_read === 1'b1) begin
                saw  = 1'b1;
                seen = mem_address;
            end
            if (BUSYWAIT !== 1'b1) begin
                done = 1'b1;
            end else begin
                stall++;
                if (stall > 60) begin
                    checks++;
                    failures++;
                    $display("FAIL %s timeout: BUSYWAIT still high after %0d cycles", name, stall);
                    done = 1'b1;
                end
            end
        end
        exp = exp_q.pop_front();
        checks++;
        if (INSTRUCTION !== exp) begin
            failures++;
            $display("FAIL %s instr: got %h expected %h", name, INSTRUCTION, exp);
        end
        checks++;
        if (stall != exp_stall) begin
            failures++;
            $display("FAIL %s stall: got %0d expected %0d", name, stall, exp_stall);
        end
        checks++;
        if (saw !== exp_miss) begin
            failures++;
            $display("FAIL %s mem_read seen: got %0d expected %0d", name, saw, exp_miss);
        end
        if (exp_miss) begin
            checks++;
            if (seen !== exp_maddr) begin
                failures++;
                $display("FAIL %s mem_address: got %h expected %h", name, seen, exp_maddr);
            end
        end
    endtask

    task automatic test_reset();
        RESET   = 1'b0;
        PC      = 32'd0;
        mem_lat = 5;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checks++;
        if (BUSYWAIT !== 1'b0) begin
            failures++;
            $display("FAIL reset busywait: got %b expected 0", BUSYWAIT);
        end
        checks++;
        if (mem_read !== 1'b0) begin
            failures++;
            $display("FAIL reset mem_read: got %b expected 0", mem_read);
        end
        checks++;
        if (mem_address !== 6'd0) begin
            failures++;
            $display("FAIL reset mem_address: got %h expected 00", mem_address);
        end
        checks++;
        if ($isunknown(INSTRUCTION)) begin
            failures++;
            $display("FAIL reset instr_x: got %h expected known value", INSTRUCTION);
        end
        @(posedge CLK);
        #1;
        RESET = 1'b1;
    endtask

    task automatic test_cold_start();
        fetch(10'h000, 1'b0, 7, 1'b1, 6'h00, "cold_start");
    endtask

    task automatic test_same_block_hits();
        fetch(10'h004, 1'b1, 0, 1'b0, 6'h00, "hit_pc4");
        fetch(10'h008, 1'b1, 0, 1'b0, 6'h00, "hit_pc8");
        fetch(10'h00C, 1'b1, 0, 1'b0, 6'h00, "hit_pc12");
    endtask

    task automatic test_conflict_eviction();
        fetch(10'h000, 1'b1, 0, 1'b0, 6'h00, "conflict_prehit");
        fetch(10'h080, 1'b1, 7, 1'b1, 6'h08, "conflict_tag1");
        fetch(10'h000, 1'b1, 7, 1'b1, 6'h00, "conflict_tag0");
        fetch(10'h084, 1'b1, 7, 1'b1, 6'h08, "conflict_tag1_again");
    endtask

    task automatic test_zero_latency();
        mem_lat = 1;
        fetch(10'h024, 1'b1, 3, 1'b1, 6'h02, "zero_lat_miss");
        fetch(10'h028, 1'b1, 0, 1'b0, 6'h00, "zero_lat_hit");
    endtask

    task automatic test_word_select();
        mem_lat = 3;
        fetch(10'h010, 1'b1, 5, 1'b1, 6'h01, "word0");
        fetch(10'h014, 1'b1, 0, 1'b0, 6'h00, "word1");
        fetch(10'h018, 1'b1, 0, 1'b0, 6'h00, "word2");
        fetch(10'h01C, 1'b1, 0, 1'b0, 6'h00, "word3");
    endtask

    task automatic test_back_to_back();
        fetch(10'h088, 1'b1, 0, 1'b0, 6'h00, "b2b_a");
        fetch(10'h014, 1'b1, 0, 1'b0, 6'h00, "b2b_b");
        fetch(10'h02C, 1'b1, 0, 1'b0, 6'h00, "b2b_c");
        fetch(10'h01C, 1'b1, 0, 1'b0, 6'h00, "b2b_d");
    endtask

    task automatic test_reset_mid_miss();
        mem_lat = 5;
        @(posedge CLK);
        #1;
        PC = 32'h0000_00A0;
        repeat (3) begin
            @(posedge CLK);
            #1;
        end
        RESET = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        checks++;
        if (mem_read !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset mem_read: got %b expected 0", mem_read);
        end
        checks++;
        if (BUSYWAIT !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset busywait: got %b expected 0", BUSYWAIT);
        end
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        fetch(10'h0A0, 1'b0, 7, 1'b1, 6'h0A, "mid_reset_refetch");
        fetch(10'h000, 1'b1, 7, 1'b1, 6'h00, "mid_reset_pc0");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        RESET    = 1'b0;
        PC       = 32'd0;
        mem_lat  = 5;
        for (int i = 0; i < 64; i++) begin
            blocks[i] = {8'hA3, i[7:0], 16'h0003, 8'hA2, i[7:0], 16'h0002,
                         8'hA1, i[7:0], 16'h0001, 8'hA0, i[7:0], 16'h0000};
        end
        blocks[0] = {32'h0B000400, 32'h00030001, 32'h00050003, 32'h00040005};
        blocks[1] = {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};

        test_reset();
        test_cold_start();
        test_same_block_hits();
        test_conflict_eviction();
        test_zero_latency();
        test_word_select();
        test_back_to_back();
        test_reset_mid_miss();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
